// File: rtl/xdma_from_remote_cfg_deframer.sv
// xdma_from_remote_cfg_deframer: splits multi-frame remote cfg messages into a header and a payload stream
module xdma_from_remote_cfg_deframer #(
    parameter int AxiWideDataWidth = 512,
    parameter int DMAIdWidth       = 4,
    parameter int AddrWidth        = 48,
    parameter int TotalFrameWidth  = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [AxiWideDataWidth-1:0]                frame_i,
    input  logic                                       frame_valid_i,
    output logic                                       frame_ready_o,
    output logic                                       hdr_dma_type_o,
    output logic [TotalFrameWidth-1:0]                 hdr_frame_length_o,
    output logic [DMAIdWidth-1:0]                      hdr_dma_id_o,
    output logic [AddrWidth-1:0]                       hdr_reader_addr_o,
    output logic [AddrWidth-1:0]                       hdr_writer_addr_o,
    output logic                                       hdr_valid_o,
    input  logic                                       hdr_ready_i,
    output logic [AxiWideDataWidth-TotalFrameWidth-2:0] payload_o,
    output logic [TotalFrameWidth-1:0]                 payload_idx_o,
    output logic                                       payload_last_o,
    output logic                                       payload_valid_o,
    input  logic                                       payload_ready_i,
    output logic                                       err_o,
    output logic                                       busy_o
);
    localparam int HdrWidth     = 1 + TotalFrameWidth + DMAIdWidth + 2 * AddrWidth;
    localparam int PlWidth      = AxiWideDataWidth - 1 - TotalFrameWidth;
    localparam int FirstPlWidth = AxiWideDataWidth - HdrWidth;

    typedef enum logic [1:0] {IDLE, HEAD, BODY, DRAIN} state_t;
    state_t state_q, state_d;

    logic [TotalFrameWidth-1:0] remaining;
    logic                       f_type;
    logic [TotalFrameWidth-1:0] f_len;
    logic [PlWidth-1:0]         first_pl, cont_pl;
    logic                       accept, hdr_hs, pl_hs;

    assign f_type   = frame_i[0];
    assign f_len    = frame_i[TotalFrameWidth:1];
    assign first_pl = {{(PlWidth-FirstPlWidth){1'b0}}, frame_i[AxiWideDataWidth-1:HdrWidth]};
    assign cont_pl  = frame_i[AxiWideDataWidth-1:TotalFrameWidth+1];
    assign accept   = frame_valid_i & frame_ready_o;
    assign hdr_hs   = hdr_valid_o & hdr_ready_i;
    assign pl_hs    = payload_valid_o & payload_ready_i;
    assign busy_o   = state_q != IDLE;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and frame acceptance; the body stage frees its slot in the same cycle it drains
    always_comb begin
        state_d       = state_q;
        frame_ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                frame_ready_o = 1'b1;
                if (accept && f_len != '0) state_d = HEAD;
            end
            HEAD: begin
                if ((!hdr_valid_o || hdr_ready_i) && (!payload_valid_o || payload_ready_i))
                    state_d = (remaining == '0) ? IDLE : BODY;
            end
            BODY: begin
                frame_ready_o = !payload_valid_o || payload_ready_i;
                if (accept && remaining == TotalFrameWidth'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pl_hs) state_d = IDLE;
            end
        endcase
    end

    // Header, payload and error registers; a new payload load overrides the drain of the previous one
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hdr_dma_type_o     <= 1'b0;
            hdr_frame_length_o <= '0;
            hdr_dma_id_o       <= '0;
            hdr_reader_addr_o  <= '0;
            hdr_writer_addr_o  <= '0;
            hdr_valid_o        <= 1'b0;
            payload_o          <= '0;
            payload_idx_o      <= '0;
            payload_last_o     <= 1'b0;
            payload_valid_o    <= 1'b0;
            remaining          <= '0;
            err_o              <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (hdr_hs) hdr_valid_o <= 1'b0;
            if (pl_hs) payload_valid_o <= 1'b0;
            if (accept && state_q == IDLE) begin
                if (f_len == '0) err_o <= 1'b1;
                else begin
                    hdr_dma_type_o     <= f_type;
                    hdr_frame_length_o <= f_len;
                    hdr_dma_id_o       <= frame_i[TotalFrameWidth+1 +: DMAIdWidth];
                    hdr_reader_addr_o  <= frame_i[TotalFrameWidth+DMAIdWidth+1 +: AddrWidth];
                    hdr_writer_addr_o  <= frame_i[TotalFrameWidth+DMAIdWidth+AddrWidth+1 +: AddrWidth];
                    hdr_valid_o        <= 1'b1;
                    payload_o          <= first_pl;
                    payload_idx_o      <= '0;
                    payload_last_o     <= f_len == TotalFrameWidth'(1);
                    payload_valid_o    <= 1'b1;
                    remaining          <= f_len - TotalFrameWidth'(1);
                end
            end else if (accept) begin
                payload_o       <= cont_pl;
                payload_idx_o   <= payload_idx_o + TotalFrameWidth'(1);
                payload_last_o  <= remaining == TotalFrameWidth'(1);
                payload_valid_o <= 1'b1;
                remaining       <= remaining - TotalFrameWidth'(1);
                err_o           <= (f_type != hdr_dma_type_o) || (f_len != hdr_frame_length_o);
            end
        end
    end
endmodule

// File: tb/tb_xdma_from_remote_cfg_deframer.sv
// tb_xdma_from_remote_cfg_deframer: directed scenarios for the remote cfg deframer
module tb_xdma_from_remote_cfg_deframer;
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [511:0] frame_i = '0;
    logic         frame_valid_i = 1'b0;
    logic         frame_ready_o;
    logic         hdr_dma_type_o;
    logic [3:0]   hdr_frame_length_o;
    logic [3:0]   hdr_dma_id_o;
    logic [47:0]  hdr_reader_addr_o;
    logic [47:0]  hdr_writer_addr_o;
    logic         hdr_valid_o;
    logic         hdr_ready_i = 1'b1;
    logic [506:0] payload_o;
    logic [3:0]   payload_idx_o;
    logic         payload_last_o;
    logic         payload_valid_o;
    logic         payload_ready_i = 1'b1;
    logic         err_o;
    logic         busy_o;

    xdma_from_remote_cfg_deframer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .frame_i(frame_i), .frame_valid_i(frame_valid_i),
        .frame_ready_o(frame_ready_o), .hdr_dma_type_o(hdr_dma_type_o),
        .hdr_frame_length_o(hdr_frame_length_o), .hdr_dma_id_o(hdr_dma_id_o),
        .hdr_reader_addr_o(hdr_reader_addr_o), .hdr_writer_addr_o(hdr_writer_addr_o),
        .hdr_valid_o(hdr_valid_o), .hdr_ready_i(hdr_ready_i), .payload_o(payload_o),
        .payload_idx_o(payload_idx_o), .payload_last_o(payload_last_o),
        .payload_valid_o(payload_valid_o), .payload_ready_i(payload_ready_i),
        .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [511:0] fr [16];
    logic [506:0] w_pl [16];
    logic [3:0]   w_idx [16];
    logic         w_last [16];
    int           w_cyc [16];
    int           acc_cyc [16];
    int           nw, sent, nerr, err_cyc, hs_cyc, stab_viol;
    bit           timed_out;

    function automatic logic [511:0] first_frame(input logic t, input logic [3:0] len, input logic [3:0] id,
                                                 input logic [47:0] rd, input logic [47:0] wr, input logic [406:0] pl);
        return {pl, wr, rd, id, len, t};
    endfunction

    function automatic logic [511:0] cont_frame(input logic t, input logic [3:0] len, input logic [506:0] pl);
        return {pl, len, t};
    endfunction

    function automatic logic [506:0] cont_pl(input int k);
        return {1'b1, 442'd0, 64'(k) * 64'h0101_0101_0101_0101};
    endfunction

    // Streams fr[0..n-1] and records every handshake, error pulse and stall-stability violation
    task automatic drive_msg(input int n, input int hr_delay, input bit pr_toggle);
        logic pv_p, hv_p, pr_p, hr_p, last_p;
        logic [506:0] pl_p;
        logic [3:0] idx_p, id_p;
        logic [47:0] rd_p;
        nw = 0; sent = 0; nerr = 0; err_cyc = -1; hs_cyc = -1; stab_viol = 0; timed_out = 1;
        pv_p = 0; hv_p = 0; pr_p = 0; hr_p = 0; last_p = 0; pl_p = '0; idx_p = '0; id_p = '0; rd_p = '0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk_i);
            hdr_ready_i = (c >= hr_delay);
            payload_ready_i = pr_toggle ? (c % 2 == 0) : 1'b1;
            frame_valid_i = (sent < n);
            frame_i = fr[4'(sent < n ? sent : 0)];
            #1;
            if (pv_p && !pr_p && (!payload_valid_o || payload_o !== pl_p || payload_idx_o !== idx_p || payload_last_o !== last_p))
                stab_viol++;
            if (hv_p && !hr_p && (!hdr_valid_o || hdr_reader_addr_o !== rd_p || hdr_dma_id_o !== id_p))
                stab_viol++;
            if (payload_valid_o && payload_ready_i && nw < 16) begin
                w_pl[nw] = payload_o; w_idx[nw] = payload_idx_o; w_last[nw] = payload_last_o; w_cyc[nw] = c;
                nw++;
            end
            if (hdr_valid_o && hdr_ready_i) hs_cyc = c;
            if (err_o) begin nerr++; err_cyc = c; end
            if (frame_valid_i && frame_ready_o && sent < 16) begin acc_cyc[sent] = c; sent++; end
            pv_p = payload_valid_o; pr_p = payload_ready_i; pl_p = payload_o; idx_p = payload_idx_o;
            last_p = payload_last_o; hv_p = hdr_valid_o; hr_p = hdr_ready_i; rd_p = hdr_reader_addr_o; id_p = hdr_dma_id_o;
            if (nw == n && sent == n && !busy_o && !hdr_valid_o && !payload_valid_o) begin
                timed_out = 0;
                break;
            end
        end
        frame_valid_i = 1'b0; hdr_ready_i = 1'b1; payload_ready_i = 1'b1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; frame_valid_i = 1'b0; hdr_ready_i = 1'b1; payload_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        checks++; if (hdr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid: got %b expected 0", hdr_valid_o); end
        checks++; if (payload_valid_o !== 1'b0) begin errors++; $display("FAIL reset_payload_valid: got %b expected 0", payload_valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL reset_frame_ready: got %b expected 1", frame_ready_o); end
        checks++; if (payload_idx_o !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", payload_idx_o); end
        checks++; if (hdr_frame_length_o !== 4'd0) begin errors++; $display("FAIL reset_len: got %0d expected 0", hdr_frame_length_o); end
        checks++; if (payload_o !== 507'd0) begin errors++; $display("FAIL reset_payload: got %0h expected 0", payload_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_single;
        @(negedge clk_i);
        frame_i = first_frame(1'b1, 4'd1, 4'h3, 48'h1000, 48'h2000, 407'hABC);
        frame_valid_i = 1'b1; hdr_ready_i = 1'b1; payload_ready_i = 1'b1;
        #1;
        checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", frame_ready_o); end
        @(negedge clk_i);
        frame_valid_i = 1'b0;
        #1;
        checks++; if (hdr_valid_o !== 1'b1) begin errors++; $display("FAIL single_hdr_valid: got %b expected 1", hdr_valid_o); end
        checks++; if (payload_valid_o !== 1'b1) begin errors++; $display("FAIL single_payload_valid: got %b expected 1", payload_valid_o); end
        checks++; if (hdr_dma_type_o !== 1'b1) begin errors++; $display("FAIL single_type: got %b expected 1", hdr_dma_type_o); end
        checks++; if (hdr_frame_length_o !== 4'd1) begin errors++; $display("FAIL single_len: got %0d expected 1", hdr_frame_length_o); end
        checks++; if (hdr_dma_id_o !== 4'h3) begin errors++; $display("FAIL single_id: got %0h expected 3", hdr_dma_id_o); end
        checks++; if (hdr_reader_addr_o !== 48'h1000) begin errors++; $display("FAIL single_reader: got %0h expected 1000", hdr_reader_addr_o); end
        checks++; if (hdr_writer_addr_o !== 48'h2000) begin errors++; $display("FAIL single_writer: got %0h expected 2000", hdr_writer_addr_o); end
        checks++; if (payload_o !== 507'hABC) begin errors++; $display("FAIL single_payload: got %0h expected abc", payload_o); end
        checks++; if (payload_idx_o !== 4'd0) begin errors++; $display("FAIL single_idx: got %0d expected 0", payload_idx_o); end
        checks++; if (payload_last_o !== 1'b1) begin errors++; $display("FAIL single_last: got %b expected 1", payload_last_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy_head: got %b expected 1", busy_o); end
        @(negedge clk_i);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b expected 0", busy_o); end
        checks++; if (hdr_valid_o !== 1'b0 || payload_valid_o !== 1'b0)
            begin errors++; $display("FAIL single_valids_done: got %b%b expected 00", hdr_valid_o, payload_valid_o); end
    endtask

    task automatic test_back_to_back;
        logic [406:0] p0;
        p0 = {1'b1, 342'd0, 64'hF00D_F00D_0000_0001};
        fr[0] = first_frame(1'b0, 4'd4, 4'h5, 48'hAAAA_0000_1111, 48'h5555_0000_2222, p0);
        for (int k = 1; k < 4; k++) fr[k] = cont_frame(1'b0, 4'd4, cont_pl(k));
        drive_msg(4, 0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got words=%0d accepts=%0d expected 4", nw, sent); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (w_idx[k] !== 4'(k)) begin errors++; $display("FAIL b2b_idx%0d: got %0d expected %0d", k, w_idx[k], k); end
            checks++; if (w_last[k] !== (k == 3)) begin errors++; $display("FAIL b2b_last%0d: got %b expected %b", k, w_last[k], k == 3); end
            checks++; if (w_pl[k] !== (k == 0 ? {100'd0, p0} : cont_pl(k)))
                begin errors++; $display("FAIL b2b_payload%0d: got %0h", k, w_pl[k]); end
        end
        checks++; if (w_cyc[0] !== 1) begin errors++; $display("FAIL b2b_latency: got %0d expected 1", w_cyc[0]); end
        checks++; if (acc_cyc[2] !== acc_cyc[1] + 1) begin errors++; $display("FAIL b2b_bubble12: got %0d expected %0d", acc_cyc[2], acc_cyc[1] + 1); end
        checks++; if (acc_cyc[3] !== acc_cyc[2] + 1) begin errors++; $display("FAIL b2b_bubble23: got %0d expected %0d", acc_cyc[3], acc_cyc[2] + 1); end
        checks++; if (nerr !== 0) begin errors++; $display("FAIL b2b_err: got %0d pulses expected 0", nerr); end
    endtask

    task automatic test_backpressure;
        fr[0] = first_frame(1'b1, 4'd3, 4'h9, 48'h0123_4567_89AB, 48'hBA98_7654_3210, 407'h77);
        for (int k = 1; k < 3; k++) fr[k] = cont_frame(1'b1, 4'd3, cont_pl(k + 8));
        drive_msg(3, 6, 1'b1);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got words=%0d accepts=%0d expected 3", nw, sent); end
        checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stab_viol); end
        checks++; if (hs_cyc !== 6) begin errors++; $display("FAIL bp_hdr_hs: got cycle %0d expected 6", hs_cyc); end
        checks++; if (acc_cyc[1] !== 7) begin errors++; $display("FAIL bp_acc1: got cycle %0d expected 7", acc_cyc[1]); end
        checks++; if (acc_cyc[2] !== 8) begin errors++; $display("FAIL bp_acc2: got cycle %0d expected 8", acc_cyc[2]); end
        checks++; if (w_cyc[0] !== 2 || w_cyc[1] !== 8 || w_cyc[2] !== 10)
            begin errors++; $display("FAIL bp_word_cycles: got %0d %0d %0d expected 2 8 10", w_cyc[0], w_cyc[1], w_cyc[2]); end
        checks++; if (w_idx[2] !== 4'd2 || w_last[2] !== 1'b1 || w_last[1] !== 1'b0)
            begin errors++; $display("FAIL bp_tail: got idx=%0d last1=%b last2=%b expected 2 0 1", w_idx[2], w_last[1], w_last[2]); end
        checks++; if (w_pl[2] !== cont_pl(10)) begin errors++; $display("FAIL bp_payload2: got %0h", w_pl[2]); end
        checks++; if (nerr !== 0) begin errors++; $display("FAIL bp_err: got %0d pulses expected 0", nerr); end
    endtask

    task automatic test_mismatch;
        fr[0] = first_frame(1'b0, 4'd3, 4'h1, 48'h10, 48'h20, 407'h5);
        fr[1] = cont_frame(1'b1, 4'd2, cont_pl(1));
        fr[2] = cont_frame(1'b0, 4'd3, cont_pl(2));
        drive_msg(3, 0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL mm_timeout: got words=%0d accepts=%0d expected 3", nw, sent); end
        checks++; if (nerr !== 1) begin errors++; $display("FAIL mm_err_count: got %0d expected 1", nerr); end
        checks++; if (err_cyc !== acc_cyc[1] + 1) begin errors++; $display("FAIL mm_err_cycle: got %0d expected %0d", err_cyc, acc_cyc[1] + 1); end
        checks++; if (w_pl[1] !== cont_pl(1)) begin errors++; $display("FAIL mm_forwarded: got %0h", w_pl[1]); end
        checks++; if (w_idx[2] !== 4'd2 || w_last[2] !== 1'b1)
            begin errors++; $display("FAIL mm_tail: got idx=%0d last=%b expected 2 1", w_idx[2], w_last[2]); end
    endtask

    task automatic test_zero_length;
        @(negedge clk_i);
        frame_i = first_frame(1'b1, 4'd0, 4'h2, 48'h1, 48'h2, 407'h3);
        frame_valid_i = 1'b1;
        #1;
        checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", frame_ready_o); end
        @(negedge clk_i);
        frame_valid_i = 1'b0;
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL zero_err: got %b expected 1", err_o); end
        checks++; if (hdr_valid_o !== 1'b0 || payload_valid_o !== 1'b0)
            begin errors++; $display("FAIL zero_valids: got %b%b expected 00", hdr_valid_o, payload_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy_o); end
        @(negedge clk_i);
        #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL zero_err_pulse: got %b expected 0", err_o); end
    endtask

    task automatic test_reset_mid;
        fr[0] = first_frame(1'b1, 4'd5, 4'h7, 48'h100, 48'h200, 407'h1);
        for (int k = 1; k < 5; k++) fr[k] = cont_frame(1'b1, 4'd5, cont_pl(k));
        @(negedge clk_i);
        frame_i = fr[0]; frame_valid_i = 1'b1; hdr_ready_i = 1'b1; payload_ready_i = 1'b1;
        @(negedge clk_i);
        frame_i = fr[1];
        @(negedge clk_i);
        #1;
        checks++; if (frame_ready_o !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b expected 1", frame_ready_o); end
        @(negedge clk_i);
        rst_ni = 1'b0; frame_valid_i = 1'b0;
        #1;
        checks++; if (payload_valid_o !== 1'b1 || payload_idx_o !== 4'd1)
            begin errors++; $display("FAIL rm_pre: got valid=%b idx=%0d expected 1 1", payload_valid_o, payload_idx_o); end
        @(negedge clk_i);
        #1;
        checks++; if (hdr_valid_o !== 1'b0 || payload_valid_o !== 1'b0)
            begin errors++; $display("FAIL rm_valids: got %b%b expected 00", hdr_valid_o, payload_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy_o); end
        checks++; if (payload_idx_o !== 4'd0) begin errors++; $display("FAIL rm_idx: got %0d expected 0", payload_idx_o); end
        rst_ni = 1'b1;
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mismatch();
        test_zero_length();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/xdma_from_remote_cfg_deframer.md
Name: xdma_from_remote_cfg_deframer

Overview:
- Receiver for the multi-frame inter-cluster configuration message arriving on the wide path (FromRemoteCfg direction).
- Accepts 512-bit frames. Splits the first frame into a header (type, id, reader/writer addresses) and streams the payload of every frame to the local cfg consumer.
- Checks continuation frames for consistency with the first frame and reports violations.

Parameters:
- AxiWideDataWidth, 512, frame width in bits.
- DMAIdWidth, 4, dma_id field width.
- AddrWidth, 48, reader/writer address width.
- TotalFrameWidth, 4, frame_length field width; legal message lengths are 1..15 frames.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous and active-low.
- frame_i  in  512  incoming frame.
- frame_valid_i  in  1  frame valid.
- frame_ready_o  out  1  frame accepted when valid and ready are both high.
- hdr_dma_type_o  out  1  0 = read, 1 = write.
- hdr_frame_length_o  out  4  total frames in the message.
- hdr_dma_id_o  out  4  DMA id.
- hdr_reader_addr_o  out  48  reader address.
- hdr_writer_addr_o  out  48  writer address.
- hdr_valid_o  out  1  header valid.
- hdr_ready_i  in  1  header consumed.
- payload_o  out  507  payload word; first-frame payload is zero-extended from 407 bits.
- payload_idx_o  out  4  frame index of this word, 0-based.
- payload_last_o  out  1  word is from the final frame.
- payload_valid_o  out  1  payload valid.
- payload_ready_i  in  1  payload consumed.
- err_o  out  1  single-cycle error pulse.
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- First-frame field map:
  - [0] dma_type
  - [4:1] frame_length
  - [8:5] dma_id
  - [56:9] reader_addr
  - [104:57] writer_addr
  - [511:105] payload (407 bits)
- Continuation-frame field map: [0] dma_type, [4:1] frame_length, [511:5] payload (507 bits).
- Reset (rst_ni low at a clock edge):
  - state = IDLE; all valids, err_o and busy_o = 0.
  - Header, payload and index registers = 0.
  - Any partial message is discarded. Reset mid-message drops the remaining frames; the upstream source is reset together with this block.
- States: IDLE, HEAD, BODY, DRAIN.
- IDLE:
  - frame_ready_o = 1.
  - On accept with frame_length == 0: err_o = 1 next cycle, no outputs, stay in IDLE.
  - On accept with frame_length > 0:
    - Register the header and the first payload; payload_idx_o = 0.
    - Register payload_last_o = (frame_length == 1).
    - Set remaining = frame_length - 1.
    - Next cycle: hdr_valid_o = 1, payload_valid_o = 1, state = HEAD.
  - Latency is 1 cycle from frame accept to valid outputs.
- HEAD:
  - frame_ready_o = 0.
  - Header and payload handshakes are independent; each valid drops on its own handshake and neither waits for the other.
  - When both have been consumed (same cycle or different cycles): go to IDLE if remaining == 0, else BODY.
- BODY:
  - frame_ready_o = ~payload_valid_o | payload_ready_i (single-register pipeline; full throughput of 1 frame/cycle).
  - On accept:
    - Load payload; payload_idx_o increments by 1.
    - remaining decrements by 1.
    - payload_last_o = (remaining == 1 before the decrement).
    - If that was the last frame, go to DRAIN.
  - Consistency check on each accepted continuation frame: if dma_type or frame_length differs from the header, err_o pulses 1 cycle after the accept. The frame is still forwarded and the count is unaffected.
  - A simultaneous consume of the current word and accept of a new word is legal; payload_valid_o stays high.
- DRAIN:
  - frame_ready_o = 0.
  - On payload handshake go to IDLE. The next message can be accepted one cycle later (1 bubble).
- Holding rule: while valid and not ready, every output holds stable.
- err_o never blocks progress and never changes state.

Test Plan:
1. Single-frame message: frame_length = 1, type = 1, id = 0x3, reader = 0x1000, writer = 0x2000, payload bits = 0xABC; both readies high.
   -> Cycle after accept: hdr_valid_o and payload_valid_o = 1 with those fields, payload_o = 0xABC, idx = 0, last = 1. Then IDLE, busy_o = 0.
2. 4-frame message streamed back-to-back with payload_ready_i always high.
   -> 4 payload words with idx 0,1,2,3; last only on idx 3; no bubbles in BODY; err_o never asserted.
3. Backpressure: 3-frame message, hdr_ready_i low for 5 cycles, payload_ready_i toggling 1/0.
   -> Outputs stable while stalled. Frames accepted only when the payload register frees. Header stays held until hdr_ready_i is high, and no continuation frame is accepted before then.
4. Mismatch: first frame length 3 type 0; second frame type 1 length 2.
   -> err_o pulses exactly once, 1 cycle after the second frame's accept. The third frame is still accepted with last = 1, idx = 2.
5. Zero length: frame_length = 0.
   -> Frame consumed, err_o = 1 for one cycle, no hdr/payload valid, state stays IDLE.
6. Reset mid-message: assert rst_ni low after frame 2 of 5.
   -> Next edge: all valids = 0, busy_o = 0. A new 1-frame message afterwards is handled per scenario 1.
